// File: rtl/bcm_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// bcm_frame_scheduler_if
//   Bundles the signals between the BCM frame scheduler, the column
//   shifter, the host swap handshake and the HUB75 panel control pins.
//
//   master : the scheduler (drives shift_start, swap_ack, rd_buf, row_addr,
//            plane, LAT, OE, frame_done, busy, shift_err)
//   slave  : the surroundings (drive enable, shift_done, swap_req)
// ---------------------------------------------------------------------------
interface bcm_frame_scheduler_if #(
  parameter int ROW_BITS = 3,
  parameter int PLANES   = 4
);
  localparam int PLANE_BITS = (PLANES > 1) ? $clog2(PLANES) : 1;

  logic                  enable;
  logic                  shift_start;
  logic                  shift_done;
  logic                  swap_req;
  logic                  swap_ack;
  logic                  rd_buf;
  logic [ROW_BITS-1:0]   row_addr;
  logic [PLANE_BITS-1:0] plane;
  logic                  LAT;
  logic                  OE;
  logic                  frame_done;
  logic                  busy;
  logic                  shift_err;

  modport master (
    input  enable, shift_done, swap_req,
    output shift_start, swap_ack, rd_buf, row_addr, plane,
           LAT, OE, frame_done, busy, shift_err
  );

  modport slave (
    output enable, shift_done, swap_req,
    input  shift_start, swap_ack, rd_buf, row_addr, plane,
           LAT, OE, frame_done, busy, shift_err
  );
endinterface

// File: rtl/bcm_frame_scheduler.sv
// ---------------------------------------------------------------------------
// bcm_frame_scheduler
//   Binary-coded-modulation scan sequencer for a HUB75 panel. For each row
//   and each bit plane it requests a row shift, latches it, lights the row
//   for BASE_TIME << plane cycles and then blanks for DEAD_TIME cycles.
//   Host buffer swaps are granted only on the frame boundary.
//
//   clk  : system clock
//   rst  : synchronous reset, active low
//   bus  : bcm_frame_scheduler_if.master (enable, shifter handshake, swap
//          handshake, row/plane/buffer select, LAT/OE, status)
//
//   Every output is a flop. Level outputs (shift_start, LAT, OE, busy) are
//   decoded from the registered state, so they trail the state register by
//   one cycle; durations are unaffected. Slot-position updates (row, plane,
//   rd_buf, frame_done, swap_ack) are registered on the BLANK exit edge, at
//   which point OE is still high.
// ---------------------------------------------------------------------------
module bcm_frame_scheduler #(
  parameter int ROW_BITS      = 3,
  parameter int PLANES        = 4,
  parameter int BASE_TIME     = 250,
  parameter int DEAD_TIME     = 250,
  parameter int SHIFT_TIMEOUT = 1024
) (
  input logic                     clk,
  input logic                     rst,
  bcm_frame_scheduler_if.master   bus
);
  localparam int PLANE_BITS = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam logic [PLANE_BITS-1:0] LAST_PLANE = PLANE_BITS'(PLANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_REQ,
    S_SHIFT_WAIT,
    S_LATCH,
    S_DISPLAY,
    S_BLANK
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic [PLANE_BITS-1:0] plane_q, plane_d;
  logic                  rd_buf_q, rd_buf_d;
  logic                  shift_err_q, shift_err_d;
  logic                  frame_done_q, frame_done_d;
  logic                  swap_ack_q, swap_ack_d;
  logic                  shift_start_q, shift_start_d;
  logic                  lat_q, lat_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic [31:0]           disp_len;

  assign disp_len = 32'(BASE_TIME) << plane_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 32'd1;
    row_d        = row_q;
    plane_d      = plane_q;
    rd_buf_d     = rd_buf_q;
    shift_err_d  = shift_err_q;
    frame_done_d = 1'b0;
    swap_ack_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.enable) state_d = S_SHIFT_REQ;
      end
      S_SHIFT_REQ: begin
        state_d = S_SHIFT_WAIT;
      end
      S_SHIFT_WAIT: begin
        if (bus.shift_done) begin
          state_d = S_LATCH;
        end else if (cnt_q == 32'(SHIFT_TIMEOUT - 1)) begin
          // Shifter is stuck: skip the latch/display of this slot but keep
          // the schedule moving so the panel does not freeze on one row.
          state_d     = S_BLANK;
          shift_err_d = 1'b1;
        end
      end
      S_LATCH: begin
        state_d = S_DISPLAY;
      end
      S_DISPLAY: begin
        if (cnt_q == disp_len - 32'd1) state_d = S_BLANK;
      end
      S_BLANK: begin
        if (cnt_q == 32'(DEAD_TIME - 1)) begin
          if (plane_q == LAST_PLANE) begin
            plane_d = '0;
            row_d   = row_q + 1'b1;
            if (row_q == '1) begin
              // Frame boundary: the only point where a swap may land.
              frame_done_d = 1'b1;
              if (bus.swap_req) begin
                rd_buf_d   = ~rd_buf_q;
                swap_ack_d = 1'b1;
              end
            end
          end else begin
            plane_d = plane_q + 1'b1;
          end
          if (bus.enable) begin
            state_d = S_SHIFT_REQ;
          end else begin
            state_d = S_IDLE;
            row_d   = '0;
            plane_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = 32'd0;

    shift_start_d = (state_q == S_SHIFT_REQ);
    lat_d         = (state_q == S_LATCH);
    oe_d          = (state_q != S_DISPLAY);
    busy_d        = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 32'd0;
      row_q         <= '0;
      plane_q       <= '0;
      rd_buf_q      <= 1'b0;
      shift_err_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      swap_ack_q    <= 1'b0;
      shift_start_q <= 1'b0;
      lat_q         <= 1'b0;
      oe_q          <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      rd_buf_q      <= rd_buf_d;
      shift_err_q   <= shift_err_d;
      frame_done_q  <= frame_done_d;
      swap_ack_q    <= swap_ack_d;
      shift_start_q <= shift_start_d;
      lat_q         <= lat_d;
      oe_q          <= oe_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.shift_start = shift_start_q;
  assign bus.swap_ack    = swap_ack_q;
  assign bus.rd_buf      = rd_buf_q;
  assign bus.row_addr    = row_q;
  assign bus.plane       = plane_q;
  assign bus.LAT         = lat_q;
  assign bus.OE          = oe_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.busy        = busy_q;
  assign bus.shift_err   = shift_err_q;
endmodule

// File: tb/tb_bcm_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bcm_frame_scheduler
//   Scoreboard bench: stimulus pushes expected panel events into exp_q, a
//   monitor turns observed waveforms into events and compares them in order.
//   Event kinds:
//     DISP  a=row b=plane c=OE-low width d=LAT-high cycles before it
//     BLANK c=cycles from OE rise until next shift_start or busy drop
//     FRAME a=row b=plane c=rd_buf prev*2+now d=swap_ack (on frame_done)
//     ACK   swap_ack without frame_done (never expected)
//     ERR   a=cycles from shift_start to shift_err rising
// ---------------------------------------------------------------------------
module tb_bcm_frame_scheduler;
  localparam int ROW_BITS  = 3;
  localparam int PLANES    = 4;
  localparam int BASE      = 250;
  localparam int DEAD      = 250;
  localparam int TMO       = 1024;
  localparam int SHIFT_LAT = 34;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcm_frame_scheduler_if #(.ROW_BITS(ROW_BITS), .PLANES(PLANES)) bus ();

  bcm_frame_scheduler #(
    .ROW_BITS(ROW_BITS), .PLANES(PLANES), .BASE_TIME(BASE),
    .DEAD_TIME(DEAD), .SHIFT_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum int {EV_DISP, EV_BLANK, EV_FRAME, EV_ACK, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int a;
    int b;
    int c;
    int d;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  bit  mon_on     = 1'b0;
  bit  shifter_on = 1'b0;

  task automatic push(input ev_kind_t k, input int a, input int b, input int c, input int d);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic observe(input ev_t got);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected: got %s a=%0d b=%0d c=%0d d=%0d required no event",
               got.kind.name(), got.a, got.b, got.c, got.d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != got.kind || e.a != got.a || e.b != got.b || e.c != got.c || e.d != got.d) begin
        failures++;
        $display("FAIL sb_event: got %s a=%0d b=%0d c=%0d d=%0d required %s a=%0d b=%0d c=%0d d=%0d",
                 got.kind.name(), got.a, got.b, got.c, got.d,
                 e.kind.name(), e.a, e.b, e.c, e.d);
      end else begin
        $display("ok   sb %s a=%0d b=%0d c=%0d d=%0d", got.kind.name(), got.a, got.b, got.c, got.d);
      end
    end
  endtask

  // Shifter model: answers SHIFT_LAT cycles after it sees shift_start.
  initial begin
    int cnt;
    bit pend;
    cnt = 0;
    pend = 1'b0;
    bus.shift_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.shift_done = 1'b0;
      if (pend) begin
        cnt++;
        if (cnt == SHIFT_LAT) begin
          bus.shift_done = 1'b1;
          pend = 1'b0;
        end
      end else if (shifter_on && bus.shift_start) begin
        pend = 1'b1;
        cnt = 0;
      end
      if (!rst) pend = 1'b0;
    end
  end

  // Monitor: converts waveforms into events.
  initial begin
    int  low_w, lat_w, blank_w, ss_cnt, disp_row, disp_plane;
    bit  blank_act, oe_prev, err_prev, rd_prev;
    int  row_prev;
    ev_t ev;
    low_w = 0; lat_w = 0; blank_w = 0; ss_cnt = 0; disp_row = 0; disp_plane = 0;
    blank_act = 1'b0; oe_prev = 1'b1; err_prev = 1'b0; rd_prev = 1'b0; row_prev = 0;
    forever begin
      @(negedge clk);
      if (!mon_on || !rst) begin
        low_w = 0; lat_w = 0; blank_w = 0; ss_cnt = 0; blank_act = 1'b0;
      end else begin
        if (bus.shift_start) ss_cnt = 0; else ss_cnt++;
        if (bus.LAT) begin
          lat_w++;
          checks++;
          if (!bus.OE) begin
            failures++;
            $display("FAIL lat_oe_overlap: got LAT=1 OE=0 required OE=1 while LAT=1");
          end
        end
        if (!bus.OE) begin
          if (oe_prev) begin
            disp_row = int'(bus.row_addr);
            disp_plane = int'(bus.plane);
            low_w = 0;
          end
          low_w++;
        end else if (!oe_prev) begin
          ev = '{EV_DISP, disp_row, disp_plane, low_w, lat_w};
          observe(ev);
          lat_w = 0;
          blank_act = 1'b1;
          blank_w = 0;
        end
        if (blank_act) begin
          if (bus.shift_start || !bus.busy) begin
            ev = '{EV_BLANK, 0, 0, blank_w, 0};
            observe(ev);
            blank_act = 1'b0;
          end else begin
            blank_w++;
          end
        end
        if (bus.frame_done) begin
          ev = '{EV_FRAME, int'(bus.row_addr), int'(bus.plane),
                 int'(rd_prev) * 2 + int'(bus.rd_buf), int'(bus.swap_ack)};
          observe(ev);
        end else if (bus.swap_ack) begin
          ev = '{EV_ACK, int'(bus.row_addr), int'(bus.plane), int'(bus.rd_buf), 1};
          observe(ev);
        end
        if (bus.shift_err && !err_prev) begin
          ev = '{EV_ERR, ss_cnt, 0, 0, 0};
          observe(ev);
        end
        if (int'(bus.row_addr) != row_prev) begin
          checks++;
          if (!(oe_prev && bus.OE)) begin
            failures++;
            $display("FAIL row_change_oe: got row %0d->%0d with OE=%0d required OE=1",
                     row_prev, bus.row_addr, bus.OE);
          end
        end
      end
      oe_prev = bus.OE;
      err_prev = bus.shift_err;
      row_prev = int'(bus.row_addr);
      rd_prev = bus.rd_buf;
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int  n;
    bit  bad;
    rst = 1'b0;
    bus.enable = 1'b1;
    bus.swap_req = 1'b0;
    shifter_on = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    // ---------------- reset values ----------------
    chk("rst_OE", int'(bus.OE), 1);
    chk("rst_LAT", int'(bus.LAT), 0);
    chk("rst_shift_start", int'(bus.shift_start), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_shift_err", int'(bus.shift_err), 0);
    chk("rst_row", int'(bus.row_addr), 0);
    chk("rst_plane", int'(bus.plane), 0);
    chk("rst_rd_buf", int'(bus.rd_buf), 0);
    chk("rst_frame_done", int'(bus.frame_done), 0);
    chk("rst_swap_ack", int'(bus.swap_ack), 0);

    // ---------------- full frame with a swap requested in row 3 ----------------
    for (int r = 0; r < (1 << ROW_BITS); r++) begin
      for (int p = 0; p < PLANES; p++) begin
        push(EV_DISP, r, p, BASE << p, 1);
        if (r == (1 << ROW_BITS) - 1 && p == PLANES - 1) push(EV_FRAME, 0, 0, 1, 1);
        push(EV_BLANK, 0, 0, DEAD, 0);
      end
    end
    mon_on = 1'b1;
    rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!bus.shift_start && n < 10);
    chk("first_shift_start_latency", n, 2);

    n = 0;
    while (bus.row_addr != 3'd3 && n < 20000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reach_row3", int'(bus.row_addr), 3);
    bus.swap_req = 1'b1;
    chk("rd_buf_before_boundary", int'(bus.rd_buf), 0);
    wait_drain("frame_drain", 45000);
    bus.swap_req = 1'b0;
    chk("frame_end_row", int'(bus.row_addr), 0);
    chk("frame_end_plane", int'(bus.plane), 0);

    // ---------------- reset in the middle of DISPLAY ----------------
    mon_on = 1'b0;
    n = 0;
    while (bus.OE && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("pre_rst_in_display", int'(bus.OE), 0);
    chk("pre_rst_rd_buf", int'(bus.rd_buf), 1);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_OE", int'(bus.OE), 1);
    chk("mid_rst_row", int'(bus.row_addr), 0);
    chk("mid_rst_plane", int'(bus.plane), 0);
    chk("mid_rst_rd_buf", int'(bus.rd_buf), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);

    // ---------------- shifter never answers ----------------
    shifter_on = 1'b0;
    push(EV_ERR, TMO, 0, 0, 0);
    push(EV_DISP, 0, 1, BASE << 1, 1);
    push(EV_BLANK, 0, 0, DEAD, 0);
    repeat (2) @(negedge clk);
    #1;
    mon_on = 1'b1;
    rst = 1'b1;
    n = 0;
    bad = 1'b0;
    while (bus.plane != 2'd1 && n < 3000) begin
      @(negedge clk); #1;
      n++;
      if (!bus.OE || bus.LAT) bad = 1'b1;
      if (bus.shift_err) shifter_on = 1'b1;
    end
    chk("timeout_reach_plane1", int'(bus.plane), 1);
    chk("timeout_no_lat_no_oe", int'(bad), 0);
    wait_drain("timeout_drain", 3000);
    chk("shift_err_sticky", int'(bus.shift_err), 1);

    // ---------------- enable dropped during plane 2 DISPLAY ----------------
    mon_on = 1'b0;
    rst = 1'b0;
    shifter_on = 1'b1;
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      push(EV_DISP, 0, p, BASE << p, 1);
      push(EV_BLANK, 0, 0, DEAD, 0);
    end
    mon_on = 1'b1;
    rst = 1'b1;
    n = 0;
    while (!(bus.plane == 2'd2 && !bus.OE) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reach_plane2_display", int'(bus.plane), 2);
    bus.enable = 1'b0;
    n = 0;
    while (bus.busy && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_row", int'(bus.row_addr), 0);
    chk("idle_plane", int'(bus.plane), 0);
    chk("err_cleared_by_rst", int'(bus.shift_err), 0);
    wait_drain("enable_drop_drain", 100);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk); #1;
      if (bus.busy || bus.shift_start || !bus.OE) bad = 1'b1;
    end
    chk("idle_stays_idle", int'(bad), 0);
    chk("sb_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcm_frame_scheduler.md
# bcm_frame_scheduler

Binary-coded-modulation frame scheduler for the HUB75 LED panel path. It sits above the column shifter and frame buffer. For every row it steps through each bit plane in order: it commands a row shift, latches the data, then enables the output for a time weighted by 2^plane before blanking. It owns `row_addr`, `LAT` and `OE`, and arbitrates double-buffer swaps requested by the host so they land only on frame boundaries.

## Interface
- `ROW_BITS`, 3: row address width; the panel has 2^ROW_BITS scanned rows.
- `PLANES`, 4: number of bit planes per row (colour depth per channel).
- `BASE_TIME`, 250: OE-low cycles for plane 0; plane p gets BASE_TIME << p.
- `DEAD_TIME`, 250: OE-high blanking cycles after every display slot.
- `SHIFT_TIMEOUT`, 1024: maximum cycles to wait for `shift_done`.
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous, active-low reset.
- `enable`, input, 1: level; 1 = scan the panel continuously.
- `shift_start`, output, 1: one-cycle pulse; shifter loads row `row_addr`, plane `plane` from buffer `rd_buf`.
- `shift_done`, input, 1: one-cycle pulse from the shifter when the row shift is complete.
- `swap_req`, input, 1: level from the host; held until `swap_ack`.
- `swap_ack`, output, 1: one-cycle pulse; `rd_buf` toggled this cycle.
- `rd_buf`, output, 1: frame buffer currently displayed.
- `row_addr`, output, ROW_BITS: panel row select.
- `plane`, output, clog2(PLANES): current bit plane.
- `LAT`, output, 1: panel latch, active high.
- `OE`, output, 1: panel output enable, active low.
- `frame_done`, output, 1: one-cycle pulse at end of each full frame.
- `busy`, output, 1: 1 in every state except IDLE.
- `shift_err`, output, 1: sticky; set on shift timeout, cleared by reset only.

## Operation
- All outputs are registered (Moore). Cycle counter is 32 bits and clears on every state change.
- Reset values: state IDLE; `OE`=1; `LAT`, `shift_start`, `swap_ack`, `frame_done`, `busy`, `shift_err`=0; `row_addr`=0, `plane`=0, `rd_buf`=0.
- IDLE: `OE`=1. Goes to SHIFT_REQ when `enable`=1.
- SHIFT_REQ: lasts 1 cycle with `shift_start`=1, then goes to SHIFT_WAIT.
- SHIFT_WAIT:
  - Goes to LATCH on `shift_done`.
  - If `shift_done` has not arrived after SHIFT_TIMEOUT cycles, sets `shift_err` and goes to BLANK, skipping LATCH and DISPLAY.
  - A `shift_done` outside SHIFT_WAIT is ignored.
- LATCH: lasts 1 cycle with `LAT`=1 and `OE`=1.
- DISPLAY: `OE`=0 for exactly BASE_TIME << plane cycles.
- BLANK: `OE`=1 for exactly DEAD_TIME cycles. On its last cycle the slot position advances:
  - `plane` increments.
  - If `plane` was PLANES-1: `plane` becomes 0 and `row_addr` increments.
  - If `row_addr` also wraps to 0: `frame_done` pulses. If `swap_req`=1 in that same cycle, `rd_buf` toggles and `swap_ack` pulses.
- After BLANK: goes to SHIFT_REQ if `enable`=1. Otherwise goes to IDLE and clears `row_addr` and `plane` to 0. `rd_buf` is kept.
- `row_addr` and `rd_buf` change only while `OE`=1, never during DISPLAY.
- Deasserting `enable` never truncates a slot: the current slot finishes through BLANK.
- A swap is never performed mid-frame. A `swap_req` dropped before the frame boundary is not acknowledged.

## Timing
- `enable` rises at cycle 0 → `shift_start` at cycle 2 (one cycle to leave IDLE, registered output).
- Slot length = 1 + Tshift + 1 + (BASE_TIME << p) + DEAD_TIME, where Tshift is the number of cycles from SHIFT_WAIT entry to `shift_done`.
- `LAT` falls in the same edge that `OE` falls; they never overlap.
- A frame is 2^ROW_BITS × PLANES slots (32 with defaults).
- When `rst` is asserted mid-operation, all outputs take their reset values on the next edge, including `OE`=1 mid-display.

## Test plan
- Reset with `enable`=1 and a shifter model answering 34 cycles after start → first `shift_start` 2 cycles after release. `LAT`=1 for 1 cycle. `OE`=0 for 250 cycles, then `OE`=1 for 250 cycles. `plane` goes 0→1 with `row_addr`=0.
- Full frame at defaults → OE-low widths repeat 250/500/1000/2000 per row. `row_addr` steps 0..7 and changes only while `OE`=1. One `frame_done` after the 32nd BLANK. `row_addr` and `plane` both back at 0.
- `swap_req` raised during row 3 and held → no ack until the frame boundary. There `frame_done`, `swap_ack` and the `rd_buf` toggle 0→1 all occur in the same cycle.
- Shifter never answers → after 1024 SHIFT_WAIT cycles `shift_err`=1. No `LAT` pulse and `OE` stays 1. The schedule continues with the next plane.
- `enable` dropped during plane 2 DISPLAY → full 1000-cycle display and 250-cycle blank complete, then IDLE with `busy`=0, `row_addr`=0, `plane`=0 and no `frame_done`.
- `rst` asserted mid-DISPLAY → next edge gives `OE`=1, `row_addr`=0, `rd_buf`=0 and state IDLE.
